wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-002 The block SHALL have parameter NUM_REGISTERS, default 32, register count; ADDRESS_WIDTH = $clog2(NUM_REGISTERS) (localparam).
REQ-003 The block SHALL have parameter MAX_WAIT, default 4, cycles port 1 may be refused before a forced grant; legal range 1..255.
REQ-004 The block SHALL have port clk, input, 1 bit, single clock, all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-006 The block SHALL have ports p0_valid_in (input, 1), p0_rd_in (input, ADDRESS_WIDTH) and p0_data_in (input, DATA_WIDTH): pipeline writeback request.
REQ-007 The block SHALL have port p0_ready_out, output, 1 bit, port 0 accept.
REQ-008 The block SHALL have ports p1_valid_in (input, 1), p1_rd_in (input, ADDRESS_WIDTH) and p1_data_in (input, DATA_WIDTH): long-latency unit (load/divide) writeback request.
REQ-009 The block SHALL have port p1_ready_out, output, 1 bit, port 1 accept.
REQ-010 The block SHALL have ports wr_en_out (output, 1), rd_out (output, ADDRESS_WIDTH) and rd_data_out (output, DATA_WIDTH), driving the register file write port.

Function
REQ-011 A port SHALL transfer in a cycle where valid and ready are both high; a requester SHALL hold valid, rd and data stable until transfer.
REQ-012 Ready outputs SHALL be combinational from valid inputs and the arbiter state; they SHALL never depend on ready.
REQ-013 In state NORMAL: p0_ready_out=1; p1_ready_out = !p0_valid_in (port 0 priority).
REQ-014 In state STARVED: p0_ready_out=0; p1_ready_out=1.
REQ-015 At most one port SHALL transfer per cycle.
REQ-016 The wait counter SHALL increment (saturating at MAX_WAIT) each cycle p1_valid_in=1 and port 1 does not transfer.
REQ-017 The wait counter SHALL clear when port 1 transfers or p1_valid_in=0.
REQ-018 NORMAL->STARVED SHALL occur on the edge where the counter reaches MAX_WAIT.
REQ-019 STARVED->NORMAL SHALL occur on the port 1 transfer edge; the counter clears on the same edge.
REQ-020 Output registers SHALL load the transferring port's rd and data one cycle after transfer (latency 1); with no transfer, wr_en_out=0 next cycle and rd_out/rd_data_out hold.
REQ-021 A transfer with rd=0 SHALL be accepted but SHALL produce wr_en_out=0 (x0 write suppressed).
REQ-022 Simultaneous valid on both ports in NORMAL SHALL grant port 0, and port 1 waits.
REQ-023 Back-to-back transfers SHALL be sustained at one per cycle with no bubble.

Reset
REQ-024 While rst=1 at a clock edge: state NORMAL, counter 0, wr_en_out=0, rd_out=0, rd_data_out=0.
REQ-025 While rst=1, both ready outputs SHALL be 0 and no transfer SHALL occur.
REQ-026 Reset mid-STARVED SHALL discard the pending grant; the requester re-presents after reset.

Structure
REQ-027 The package rv_pkg SHALL hold the typedef wb_state_e {NORMAL, STARVED}, the DATA_WIDTH/NUM_REGISTERS defaults and the wb_req_t struct {valid, rd, data}.
REQ-028 The block SHALL be a single module with no sub-module; its output feeds rf directly.

Verification
REQ-029 Reset, then p0 valid with rd=5, data=0xDEADBEEF -> next cycle wr_en_out=1, rd_out=5, rd_data_out=0xDEADBEEF.
REQ-030 p0 and p1 both valid (p0 rd=3, p1 rd=7) continuously with MAX_WAIT=4 -> p1_ready_out=0 for 4 cycles, then STARVED, p1 transfers on cycle 5 with p0_ready_out=0, and NORMAL follows.
REQ-031 p1 only, rd=0, data=0x1234 -> p1_ready_out=1 and transfer occurs, but wr_en_out stays 0.
REQ-032 p0 streams rd=1..8 on consecutive cycles -> wr_en_out=1 for 8 consecutive cycles, rd_out 1..8 in order.
REQ-033 rst asserted in STARVED with counter=4 -> next cycle NORMAL, counter 0, wr_en_out=0, both ready=0 during rst.
REQ-034 p1 valid 2 cycles, deasserted 1 cycle, then revalid -> counter clears to 0, and STARVED is not entered before 4 fresh refused cycles.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared register-file writeback types: arbiter state, default widths and the
// writeback request payload.
package rv_pkg;

  localparam int unsigned RV_DATA_WIDTH    = 32;
  localparam int unsigned RV_NUM_REGISTERS = 32;
  localparam int unsigned RV_ADDRESS_WIDTH = $clog2(RV_NUM_REGISTERS);

  // NORMAL: pipeline port has priority. STARVED: long-latency port is forced through.
  typedef enum logic {
    NORMAL  = 1'b0,
    STARVED = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic                        valid;
    logic [RV_ADDRESS_WIDTH-1:0] rd;
    logic [RV_DATA_WIDTH-1:0]    data;
  } wb_req_t;

endpackage

// File: rtl/wb_arbiter.sv
// Two-port register-file writeback arbiter.
// Port 0 (pipeline) has fixed priority; port 1 (load/divide unit) is forced
// through after MAX_WAIT consecutive refused cycles. Writes to x0 are accepted
// but never reach the register file.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   p0_valid_in/p0_rd_in/p0_data_in  pipeline writeback request
//   p0_ready_out                     port 0 accept (combinational)
//   p1_valid_in/p1_rd_in/p1_data_in  long-latency unit writeback request
//   p1_ready_out                     port 1 accept (combinational)
//   wr_en_out/rd_out/rd_data_out     registered register-file write port
module wb_arbiter
  import rv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = RV_DATA_WIDTH,
  parameter int unsigned NUM_REGISTERS = RV_NUM_REGISTERS,
  parameter int unsigned MAX_WAIT      = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 p0_valid_in,
  input  logic [$clog2(NUM_REGISTERS)-1:0]     p0_rd_in,
  input  logic [DATA_WIDTH-1:0]                p0_data_in,
  output logic                                 p0_ready_out,
  input  logic                                 p1_valid_in,
  input  logic [$clog2(NUM_REGISTERS)-1:0]     p1_rd_in,
  input  logic [DATA_WIDTH-1:0]                p1_data_in,
  output logic                                 p1_ready_out,
  output logic                                 wr_en_out,
  output logic [$clog2(NUM_REGISTERS)-1:0]     rd_out,
  output logic [DATA_WIDTH-1:0]                rd_data_out
);

  localparam int unsigned ADDRESS_WIDTH = $clog2(NUM_REGISTERS);
  localparam int unsigned CNT_W         = 8;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_WAIT);

  wb_state_e         state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  wait_cnt_next;
  logic              p0_xfer;
  logic              p1_xfer;

  // Accept logic: depends only on valids, state and reset, never on ready.
  always_comb begin
    p0_ready_out = 1'b0;
    p1_ready_out = 1'b0;
    if (!rst) begin
      case (state)
        NORMAL: begin
          p0_ready_out = 1'b1;
          p1_ready_out = !p0_valid_in;
        end
        STARVED: begin
          p0_ready_out = 1'b0;
          p1_ready_out = 1'b1;
        end
        default: begin
          p0_ready_out = 1'b0;
          p1_ready_out = 1'b0;
        end
      endcase
    end
    p0_xfer = p0_valid_in && p0_ready_out;
    p1_xfer = p1_valid_in && p1_ready_out;
  end

  // Refused-cycle counter for port 1, saturating at MAX_WAIT.
  always_comb begin
    wait_cnt_next = wait_cnt;
    if (!p1_valid_in || p1_xfer) begin
      wait_cnt_next = '0;
    end else if (wait_cnt < MAX_CNT) begin
      wait_cnt_next = CNT_W'(wait_cnt + CNT_W'(1));
    end
  end

  // State, counter and register-file write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= NORMAL;
      wait_cnt    <= '0;
      wr_en_out   <= 1'b0;
      rd_out      <= '0;
      rd_data_out <= '0;
    end else begin
      wait_cnt  <= wait_cnt_next;
      wr_en_out <= 1'b0;

      case (state)
        NORMAL:  if (wait_cnt_next == MAX_CNT) state <= STARVED;
        // A requester that withdraws while starved releases the forced grant.
        STARVED: if (p1_xfer || !p1_valid_in) state <= NORMAL;
        default: state <= NORMAL;
      endcase

      if (p0_xfer) begin
        rd_out      <= p0_rd_in;
        rd_data_out <= p0_data_in;
        wr_en_out   <= (p0_rd_in != ADDRESS_WIDTH'(0));
      end else if (p1_xfer) begin
        rd_out      <= p1_rd_in;
        rd_data_out <= p1_data_in;
        wr_en_out   <= (p1_rd_in != ADDRESS_WIDTH'(0));
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a reference model predicts ready
// outputs and queues the expected write-port contents, which are popped and
// compared one cycle later; directed scenarios add constant checks.
module tb_wb_arbiter;
  import rv_pkg::*;

  localparam int unsigned DW       = 32;
  localparam int unsigned NR       = 32;
  localparam int unsigned AW       = $clog2(NR);
  localparam int unsigned MAX_WAIT = 4;

  typedef struct {
    logic          wr;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_valid_in, p1_valid_in;
  logic [AW-1:0] p0_rd_in, p1_rd_in;
  logic [DW-1:0] p0_data_in, p1_data_in;
  logic          p0_ready_out, p1_ready_out;
  logic          wr_en_out;
  logic [AW-1:0] rd_out;
  logic [DW-1:0] rd_data_out;

  int checks   = 0;
  int failures = 0;

  exp_t          exp_q[$];
  wb_state_e     m_state = NORMAL;
  int            m_cnt   = 0;
  logic [AW-1:0] m_rd    = '0;
  logic [DW-1:0] m_data  = '0;
  logic          last_p0r, last_p1r, last_x0, last_x1;

  wb_arbiter #(
    .DATA_WIDTH   (DW),
    .NUM_REGISTERS(NR),
    .MAX_WAIT     (MAX_WAIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .p0_valid_in (p0_valid_in),
    .p0_rd_in    (p0_rd_in),
    .p0_data_in  (p0_data_in),
    .p0_ready_out(p0_ready_out),
    .p1_valid_in (p1_valid_in),
    .p1_rd_in    (p1_rd_in),
    .p1_data_in  (p1_data_in),
    .p1_ready_out(p1_ready_out),
    .wr_en_out   (wr_en_out),
    .rd_out      (rd_out),
    .rd_data_out (rd_data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, check readies against the model, queue the
  // predicted write port, then pop and compare after the edge.
  task automatic step(input logic r,
                      input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    exp_t e;
    logic er0, er1, x0, x1;
    @(negedge clk);
    rst = r;
    p0_valid_in = v0; p0_rd_in = a0; p0_data_in = d0;
    p1_valid_in = v1; p1_rd_in = a1; p1_data_in = d1;
    #1;
    er0 = !r && (m_state == NORMAL);
    er1 = !r && ((m_state == NORMAL) ? !v0 : 1'b1);
    check("p0_ready", 64'(p0_ready_out), 64'(er0));
    check("p1_ready", 64'(p1_ready_out), 64'(er1));
    last_p0r = p0_ready_out;
    last_p1r = p1_ready_out;
    x0 = v0 && er0;
    x1 = v1 && er1;
    e.wr = 1'b0;
    if (r) begin
      m_state = NORMAL; m_cnt = 0; m_rd = '0; m_data = '0;
    end else begin
      if (x0) begin
        m_rd = a0; m_data = d0; e.wr = (a0 != '0);
      end else if (x1) begin
        m_rd = a1; m_data = d1; e.wr = (a1 != '0);
      end
      if (!v1 || x1) m_cnt = 0;
      else if (m_cnt < int'(MAX_WAIT)) m_cnt++;
      if (m_state == NORMAL && m_cnt == int'(MAX_WAIT)) m_state = STARVED;
      else if (m_state == STARVED && (x1 || !v1)) m_state = NORMAL;
    end
    e.rd = m_rd;
    e.data = m_data;
    exp_q.push_back(e);
    last_x0 = x0;
    last_x1 = x1;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("wr_en", 64'(wr_en_out), 64'(e.wr));
    check("rd_out", 64'(rd_out), 64'(e.rd));
    check("rd_data", 64'(rd_data_out), 64'(e.data));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic both(input logic r);
    step(r, 1'b1, AW'(3), 32'hAAAA_0003, 1'b1, AW'(7), 32'hBBBB_0007);
  endtask

  initial begin
    logic          v0, v1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    int            n_wr;

    rst = 1'b1;
    p0_valid_in = 1'b0; p0_rd_in = '0; p0_data_in = '0;
    p1_valid_in = 1'b0; p1_rd_in = '0; p1_data_in = '0;

    // Reset with requests present: no accept, zero outputs.
    step(1'b1, 1'b1, AW'(2), 32'h1, 1'b1, AW'(4), 32'h2);
    check("rst_p0_ready", 64'(last_p0r), 64'd0);
    check("rst_p1_ready", 64'(last_p1r), 64'd0);
    check("rst_wr_en", 64'(wr_en_out), 64'd0);
    check("rst_rd_data", 64'(rd_data_out), 64'd0);
    idle();

    // Single pipeline write.
    step(1'b0, 1'b1, AW'(5), 32'hDEAD_BEEF, 1'b0, '0, '0);
    check("p0_wr_en", 64'(wr_en_out), 64'd1);
    check("p0_rd", 64'(rd_out), 64'd5);
    check("p0_data", 64'(rd_data_out), 64'hDEAD_BEEF);
    idle();
    check("idle_hold_rd", 64'(rd_out), 64'd5);
    check("idle_wr_en", 64'(wr_en_out), 64'd0);

    // Contention: port 1 refused MAX_WAIT cycles, then forced through.
    for (int i = 0; i < int'(MAX_WAIT); i++) begin
      both(1'b0);
      check("starve_refused", 64'(last_p1r), 64'd0);
    end
    both(1'b0);
    check("starved_p0_ready", 64'(last_p0r), 64'd0);
    check("starved_p1_ready", 64'(last_p1r), 64'd1);
    check("starved_rd", 64'(rd_out), 64'd7);
    step(1'b0, 1'b1, AW'(3), 32'hAAAA_0003, 1'b0, '0, '0);
    check("back_normal_p0", 64'(last_p0r), 64'd1);
    idle();

    // Port 1 write to x0: accepted, suppressed.
    step(1'b0, 1'b0, '0, '0, 1'b1, AW'(0), 32'h1234);
    check("x0_p1_ready", 64'(last_p1r), 64'd1);
    check("x0_wr_en", 64'(wr_en_out), 64'd0);
    idle();

    // Back-to-back streaming.
    n_wr = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, AW'(i), DW'(32'h100 + i), 1'b0, '0, '0);
      if (wr_en_out === 1'b1) n_wr++;
      check("stream_rd", 64'(rd_out), 64'(i));
    end
    check("stream_count", 64'(n_wr), 64'd8);
    idle();

    // Reset while starved discards the grant.
    for (int i = 0; i < int'(MAX_WAIT); i++) both(1'b0);
    both(1'b1);
    check("rst_starved_p0", 64'(last_p0r), 64'd0);
    check("rst_starved_p1", 64'(last_p1r), 64'd0);
    check("rst_starved_wr", 64'(wr_en_out), 64'd0);
    both(1'b0);
    check("post_rst_normal", 64'(last_p1r), 64'd0);
    idle();

    // Gap in port 1 valid clears the wait count.
    both(1'b0);
    both(1'b0);
    step(1'b0, 1'b1, AW'(3), 32'h3, 1'b0, '0, '0);
    for (int i = 0; i < int'(MAX_WAIT); i++) begin
      both(1'b0);
      check("gap_refused", 64'(last_p1r), 64'd0);
    end
    both(1'b0);
    check("gap_forced", 64'(last_p1r), 64'd1);
    idle();

    // Random traffic; requesters hold until transfer.
    v0 = 1'b0; v1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    for (int i = 0; i < 80; i++) begin
      if (!v0 && ($urandom_range(0, 2) != 0)) begin
        v0 = 1'b1; a0 = AW'($urandom); d0 = $urandom;
      end
      if (!v1 && ($urandom_range(0, 1) != 0)) begin
        v1 = 1'b1; a1 = AW'($urandom); d1 = $urandom;
      end
      step(1'b0, v0, a0, d0, v1, a1, d1);
      if (last_x0) v0 = 1'b0;
      if (last_x1) v1 = 1'b0;
    end
    idle();

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
